// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM symbol scheduler.
//   state_t        : scheduler FSM encoding
//   MOD_QPSK/QAM16 : modulation select values (cfg_qam16 / map_qam16)
//   bits_per_slot  : payload bits consumed by one data slot
//   slot_mask      : mask of the valid bits inside a 4-bit slot word
//   LFSR_SEED/TAPS : scrambler polynomial x^7 + x^4 + 1 and its frame seed
//   lfsr_step      : one scrambler shift
//   PILOT_BITS_DEF : default word driven on pilot slots
package ofdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MOD_QPSK  = 1'b0;
  localparam logic MOD_QAM16 = 1'b1;

  localparam logic [3:0] PILOT_BITS_DEF = 4'b0000;

  localparam logic [6:0] LFSR_SEED = 7'h7F;
  // Feedback taps for x^7 and x^4 (bit 6 and bit 3 of the shift register).
  localparam logic [6:0] LFSR_TAPS = 7'b1001000;

  function automatic logic [3:0] bits_per_slot(input logic qam16);
    return (qam16 == MOD_QAM16) ? 4'd4 : 4'd2;
  endfunction

  function automatic logic [3:0] slot_mask(input logic qam16);
    return (qam16 == MOD_QPSK) ? 4'b0011 : 4'b1111;
  endfunction

  // Output bit is s[6]; the feedback bit enters at the bottom.
  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ofdm_scrambler.sv
// Payload scrambler for the OFDM symbol scheduler (built only with
// OFDM_SCRAMBLER_EN defined).
//   clk, rst : clock, asynchronous active-high reset
//   seed     : reload LFSR_SEED (frame start)
//   adv      : a data slot word is being taken; advance 2 (QPSK) or 4 (16-QAM)
//   qam16    : modulation of the current frame
//   din      : raw slot word, LSB is the first payload bit
//   dout     : din XOR keystream, keystream bit i applied to din[i]
`ifdef OFDM_SCRAMBLER_EN
module ofdm_scrambler
  import ofdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       seed,
  input  logic       adv,
  input  logic       qam16,
  input  logic [3:0] din,
  output logic [3:0] dout
);

  logic [6:0] lfsr;
  logic [6:0] st2;
  logic [6:0] st4;
  logic [3:0] ks;

  // Unroll four shifts: keystream bits for the slot plus the states after
  // two and four data bits.
  always_comb begin
    logic [6:0] s;
    s   = lfsr;
    ks  = '0;
    st2 = lfsr;
    for (int i = 0; i < 4; i++) begin
      ks[i] = s[6];
      s     = lfsr_step(s);
      if (i == 1) st2 = s;
    end
    st4 = s;
  end

  assign dout = din ^ (ks & slot_mask(qam16));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (seed) begin
      lfsr <= LFSR_SEED;
    end else if (adv) begin
      lfsr <= (qam16 == MOD_QAM16) ? st4 : st2;
    end
  end

endmodule
`endif

// File: rtl/ofdm_symbol_scheduler.sv
// OFDM symbol scheduler: pulls payload bytes, slices them LSB-first into
// QPSK (2 b) or 16-QAM (4 b) slot words, inserts pilot slots every
// cfg_pilot_per subcarriers, pads the final OFDM symbol and hands every
// subcarrier slot to the mapper over valid/ready.
// Optional feature: define OFDM_SCRAMBLER_EN to XOR data bits with a
// x^7+x^4+1 LFSR keystream (seed 7'h7F at each frame start).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : frame start pulse (ignored unless idle, nsc!=0, len!=0)
//   cfg_qam16/nsc/pilot_per/len : frame configuration, latched at start
//   in_valid/in_data/in_ready   : payload byte stream
//   map_valid/map_ready         : slot handshake to the mapper
//   map_bits/map_qam16/map_pilot/map_last : slot word and attributes
//   busy, done, ofdm_cnt        : frame status
module ofdm_symbol_scheduler
  import ofdm_pkg::*;
#(
  parameter int         NSC_W      = 6,
  parameter logic [3:0] PILOT_BITS = PILOT_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cfg_qam16,
  input  logic [NSC_W-1:0] cfg_nsc,
  input  logic [3:0]       cfg_pilot_per,
  input  logic [7:0]       cfg_len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             map_valid,
  input  logic             map_ready,
  output logic [3:0]       map_bits,
  output logic             map_qam16,
  output logic             map_pilot,
  output logic             map_last,
  output logic             busy,
  output logic             done,
  output logic [7:0]       ofdm_cnt
);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state;
  logic             qam16_r;
  logic [NSC_W-1:0] nsc_m1_r;
  logic [3:0]       pper_r;
  logic [7:0]       bytes_left;
  logic [3:0]       bits_left;
  logic [7:0]       buf_r;
  logic [NSC_W-1:0] sc_idx;
  logic [3:0]       pil_cnt;

  logic             start_ok;
  logic             byte_acc;
  logic             xfer;
  logic [3:0]       bps;
  logic             is_data;
  logic             sym_end;
  logic [3:0]       nx_bits;
  logic [7:0]       nx_buf;
  logic [NSC_W-1:0] nx_sc;
  logic [3:0]       nx_pil;
  logic             nx_last;
  logic             frame_end;
  logic [3:0]       ctx_pper;
  logic [3:0]       ctx_pil;
  logic [3:0]       ctx_bits;
  logic [7:0]       ctx_bytes;
  logic             dec_pilot;
  logic             dec_data;
  logic             dec_fetch;
  logic [3:0]       raw_word;
  logic [3:0]       scr_word;
  logic [3:0]       data_word;

  assign start_ok = (state == ST_IDLE) && start && (cfg_nsc != '0) && (cfg_len != 8'd0);
  assign byte_acc = (state == ST_FETCH) && in_valid && in_ready;
  assign xfer     = (state == ST_EMIT) && map_valid && map_ready;
  assign bps      = bits_per_slot(qam16_r);
  // Pad slots are the only non-pilot slots emitted with an empty buffer.
  assign is_data  = !map_pilot && (bits_left != 4'd0);
  assign sym_end  = (sc_idx == nsc_m1_r);

  // Slot context after the current slot is transferred.
  always_comb begin
    nx_bits = bits_left;
    nx_buf  = buf_r;
    if (is_data) begin
      nx_bits = bits_left - bps;
      nx_buf  = buf_r >> bps;
    end
    nx_sc = sym_end ? '0 : sc_idx + NSC_W'(1);
    if (sym_end || (pil_cnt == pper_r - 4'd1)) begin
      nx_pil = 4'd0;
    end else begin
      nx_pil = pil_cnt + 4'd1;
    end
    nx_last   = (nx_sc == nsc_m1_r);
    frame_end = sym_end && (bytes_left == 8'd0) && (nx_bits == 4'd0);
  end

  // Slot decision: at frame start from the fresh configuration, otherwise
  // from the post-transfer context.
  always_comb begin
    if (state == ST_IDLE) begin
      ctx_pper  = cfg_pilot_per;
      ctx_pil   = 4'd0;
      ctx_bits  = 4'd0;
      ctx_bytes = cfg_len;
    end else begin
      ctx_pper  = pper_r;
      ctx_pil   = nx_pil;
      ctx_bits  = nx_bits;
      ctx_bytes = bytes_left;
    end
    dec_pilot = (ctx_pper != 4'd0) && (ctx_pil == 4'd0);
    dec_data  = !dec_pilot && (ctx_bits != 4'd0);
    dec_fetch = !dec_pilot && !dec_data && (ctx_bytes != 8'd0);
  end

  assign raw_word = (state == ST_FETCH) ? in_data[3:0] : nx_buf[3:0];

`ifdef OFDM_SCRAMBLER_EN
  logic load_data;
  assign load_data = byte_acc || (xfer && !frame_end && dec_data);

  ofdm_scrambler u_scrambler (
    .clk   (clk),
    .rst   (rst),
    .seed  (start_ok),
    .adv   (load_data),
    .qam16 (qam16_r),
    .din   (raw_word),
    .dout  (scr_word)
  );
`else
  assign scr_word = raw_word;
`endif

  assign data_word = scr_word & slot_mask(qam16_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      qam16_r    <= 1'b0;
      nsc_m1_r   <= '0;
      pper_r     <= 4'd0;
      bytes_left <= 8'd0;
      bits_left  <= 4'd0;
      buf_r      <= 8'd0;
      sc_idx     <= '0;
      pil_cnt    <= 4'd0;
      ofdm_cnt   <= 8'd0;
      in_ready   <= 1'b0;
      map_valid  <= 1'b0;
      map_bits   <= 4'd0;
      map_qam16  <= 1'b0;
      map_pilot  <= 1'b0;
      map_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            qam16_r    <= cfg_qam16;
            nsc_m1_r   <= cfg_nsc - NSC_W'(1);
            pper_r     <= cfg_pilot_per;
            bytes_left <= cfg_len;
            bits_left  <= 4'd0;
            sc_idx     <= '0;
            pil_cnt    <= 4'd0;
            ofdm_cnt   <= 8'd0;
            busy       <= 1'b1;
            if (dec_pilot) begin
              state     <= ST_EMIT;
              map_valid <= 1'b1;
              map_bits  <= PILOT_BITS;
              map_pilot <= 1'b1;
              map_qam16 <= cfg_qam16;
              map_last  <= (cfg_nsc == NSC_W'(1));
            end else begin
              state    <= ST_FETCH;
              in_ready <= 1'b1;
            end
          end
        end

        ST_FETCH: begin
          if (byte_acc) begin
            buf_r      <= in_data;
            bits_left  <= 4'd8;
            bytes_left <= bytes_left - 8'd1;
            in_ready   <= 1'b0;
            state      <= ST_EMIT;
            map_valid  <= 1'b1;
            map_bits   <= data_word;
            map_pilot  <= 1'b0;
            map_qam16  <= qam16_r;
            map_last   <= sym_end;
          end
        end

        ST_EMIT: begin
          if (xfer) begin
            buf_r     <= nx_buf;
            bits_left <= nx_bits;
            sc_idx    <= nx_sc;
            pil_cnt   <= nx_pil;
            if (sym_end) begin
              ofdm_cnt <= sat_inc(ofdm_cnt);
            end
            if (frame_end) begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              map_valid <= 1'b0;
              map_bits  <= 4'd0;
              map_pilot <= 1'b0;
              map_qam16 <= 1'b0;
              map_last  <= 1'b0;
            end else if (dec_fetch) begin
              state     <= ST_FETCH;
              in_ready  <= 1'b1;
              map_valid <= 1'b0;
              map_bits  <= 4'd0;
              map_pilot <= 1'b0;
              map_last  <= 1'b0;
            end else begin
              map_bits  <= dec_pilot ? PILOT_BITS : (dec_data ? data_word : 4'd0);
              map_pilot <= dec_pilot;
              map_qam16 <= qam16_r;
              map_last  <= nx_last;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// Self-checking bench for ofdm_symbol_scheduler: directed frames plus
// randomized frames, checked against a slot-list model built from the
// frame rules (bit stream, pilot positions, symbol padding).
module tb_ofdm_symbol_scheduler;

  localparam int         NSC_W = 6;
  localparam logic [3:0] PB    = 4'b0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             cfg_qam16;
  logic [NSC_W-1:0] cfg_nsc;
  logic [3:0]       cfg_pilot_per;
  logic [7:0]       cfg_len;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             map_valid;
  logic             map_ready;
  logic [3:0]       map_bits;
  logic             map_qam16;
  logic             map_pilot;
  logic             map_last;
  logic             busy;
  logic             done;
  logic [7:0]       ofdm_cnt;

  always #5 clk = ~clk;

  ofdm_symbol_scheduler #(.NSC_W(NSC_W), .PILOT_BITS(PB)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_qam16     (cfg_qam16),
    .cfg_nsc       (cfg_nsc),
    .cfg_pilot_per (cfg_pilot_per),
    .cfg_len       (cfg_len),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .map_valid     (map_valid),
    .map_ready     (map_ready),
    .map_bits      (map_bits),
    .map_qam16     (map_qam16),
    .map_pilot     (map_pilot),
    .map_last      (map_last),
    .busy          (busy),
    .done          (done),
    .ofdm_cnt      (ofdm_cnt)
  );

  typedef struct packed {
    logic [3:0] bits;
    logic       pilot;
    logic       last;
    logic       qam;
  } slot_t;

  slot_t      exp_q[$];
  logic [7:0] model_bytes[$];
  logic [7:0] byte_q[$];
  int         exp_syms;
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  int         frame_d0 = 0;
  int         slots_seen = 0;
  bit         chk_en = 1'b0;
  bit         rand_ready = 1'b0;
  bit         rand_gap = 1'b0;
  bit         force_low = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected slot list: payload bits LSB-first per byte, pilot where the
  // subcarrier index is a multiple of P, data while bits remain, pads to
  // the end of the symbol in which the bit stream runs dry.
  task automatic build_model(input logic q, input int nsc, input int p);
    logic bitsq[$];
    int   bps;
    int   syms;
`ifdef OFDM_SCRAMBLER_EN
    logic [6:0] l;
    l = 7'h7F;
`endif
    bps  = q ? 4 : 2;
    syms = 0;
    exp_q.delete();
    foreach (model_bytes[i]) begin
      logic [7:0] mb;
      mb = model_bytes[i];
      for (int b = 0; b < 8; b++) begin
        logic bt;
        bt = mb[b];
`ifdef OFDM_SCRAMBLER_EN
        bt = bt ^ l[6];
        l  = {l[5:0], l[6] ^ l[3]};
`endif
        bitsq.push_back(bt);
      end
    end
    do begin
      for (int s = 0; s < nsc; s++) begin
        slot_t e;
        e.qam   = q;
        e.last  = (s == nsc - 1);
        e.pilot = 1'b0;
        e.bits  = 4'd0;
        if (p != 0 && (s % p) == 0) begin
          e.pilot = 1'b1;
          e.bits  = PB;
        end else if (bitsq.size() > 0) begin
          for (int k = 0; k < bps; k++) e.bits[k] = bitsq.pop_front();
        end
        exp_q.push_back(e);
      end
      syms++;
    end while (bitsq.size() > 0);
    exp_syms = (syms > 255) ? 255 : syms;
  endtask

  task automatic start_frame(input logic q, input int nsc, input int p, input int len,
                             input logic [7:0] fixed, input bit use_fixed);
    model_bytes.delete();
    for (int i = 0; i < len; i++) model_bytes.push_back(use_fixed ? fixed : 8'($urandom));
    build_model(q, nsc, p);
    byte_q        = model_bytes;
    slots_seen    = 0;
    frame_d0      = done_cnt;
    cfg_qam16     = q;
    cfg_nsc       = NSC_W'(nsc);
    cfg_pilot_per = 4'(p);
    cfg_len       = 8'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    int n;
    n = 0;
    while (done_cnt == frame_d0 && n < 6000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({tag, "_done_count"}, 32'(done_cnt - frame_d0), 32'd1);
    @(negedge clk);
    chk({tag, "_ofdm_cnt"}, 32'(ofdm_cnt), 32'(exp_syms));
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    chk({tag, "_slots_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_bytes_left"}, 32'(byte_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Compare process: every valid slot against the head of the model list.
  always @(negedge clk) begin : cmp
    slot_t e;
    if (!rst && chk_en) begin
      if (map_valid) begin
        if (exp_q.size() == 0) begin
          chk("slot_extra", 32'(map_valid), 32'd0);
        end else begin
          e = exp_q[0];
          chk("map_bits", 32'(map_bits), 32'(e.bits));
          chk("map_pilot", 32'(map_pilot), 32'(e.pilot));
          chk("map_last", 32'(map_last), 32'(e.last));
          chk("map_qam16", 32'(map_qam16), 32'(e.qam));
          chk("in_ready_with_valid", 32'(in_ready), 32'd0);
          if (map_ready) begin
            void'(exp_q.pop_front());
            slots_seen++;
          end
        end
      end
      if (done) begin
        chk("done_with_slots_pending", 32'(exp_q.size()), 32'd0);
        done_cnt++;
      end
    end
  end

  // Payload byte source.
  initial begin : src
    bit acc;
    in_valid = 1'b0;
    in_data  = 8'd0;
    forever begin
      @(negedge clk);
      acc = in_valid && in_ready && !rst;
      @(posedge clk); #1;
      if (acc && byte_q.size() > 0) void'(byte_q.pop_front());
      if (byte_q.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = byte_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
  end

  // Mapper ready.
  initial begin : snk
    map_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (force_low)       map_ready = 1'b0;
      else if (rand_ready) map_ready = ($urandom_range(0, 2) != 0);
      else                 map_ready = 1'b1;
    end
  end

  initial begin : main
    logic [3:0] lit4 [4];
    logic [3:0] lit6 [6];
    logic [5:0] pil6;
    int         n;
    rst = 1'b1;
    start = 1'b0;
    cfg_qam16 = 1'b0;
    cfg_nsc = '0;
    cfg_pilot_per = 4'd0;
    cfg_len = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_map_valid", 32'(map_valid), 32'd0);
    chk("rst_map_bits", 32'(map_bits), 32'd0);
    chk("rst_map_qam16", 32'(map_qam16), 32'd0);
    chk("rst_map_pilot", 32'(map_pilot), 32'd0);
    chk("rst_map_last", 32'(map_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ofdm_cnt", 32'(ofdm_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // QPSK nsc=4 len=1 byte 0xB4.
    start_frame(1'b0, 4, 0, 1, 8'hB4, 1'b1);
`ifndef OFDM_SCRAMBLER_EN
    lit4 = '{4'h0, 4'h1, 4'h3, 4'h2};
    for (int i = 0; i < 4; i++) chk("pin_c1_bits", 32'(exp_q[i].bits), 32'(lit4[i]));
`endif
    chk("pin_c1_last", 32'(exp_q[3].last), 32'd1);
    chk("pin_c1_syms", 32'(exp_syms), 32'd1);
    finish_frame("c1");

    // 16-QAM nsc=4 len=1 byte 0x5A: two data slots then two pads.
    start_frame(1'b1, 4, 0, 1, 8'h5A, 1'b1);
`ifndef OFDM_SCRAMBLER_EN
    lit4 = '{4'hA, 4'h5, 4'h0, 4'h0};
    for (int i = 0; i < 4; i++) chk("pin_c2_bits", 32'(exp_q[i].bits), 32'(lit4[i]));
`endif
    finish_frame("c2");

    // QPSK nsc=6 P=3 byte 0xE4: pilot,0,1,pilot,2,3.
    start_frame(1'b0, 6, 3, 1, 8'hE4, 1'b1);
`ifndef OFDM_SCRAMBLER_EN
    lit6 = '{PB, 4'h0, 4'h1, PB, 4'h2, 4'h3};
    pil6 = 6'b001001;
    for (int i = 0; i < 6; i++) begin
      chk("pin_c3_bits", 32'(exp_q[i].bits), 32'(lit6[i]));
      chk("pin_c3_pilot", 32'(exp_q[i].pilot), 32'(pil6[i]));
    end
`endif
    finish_frame("c3");

    // Case 1 with map_ready held low for 5 cycles on the second slot.
    start_frame(1'b0, 4, 0, 1, 8'hB4, 1'b1);
    n = 0;
    while (slots_seen < 1 && n < 200) begin
      @(posedge clk);
      n++;
    end
    force_low = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_map_valid", 32'(map_valid), 32'd1);
`ifndef OFDM_SCRAMBLER_EN
      chk("bp_map_bits", 32'(map_bits), 32'd1);
`endif
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    force_low = 1'b0;
    #1;
    finish_frame("bp");

    // QPSK nsc=2 len=1: two symbols; a start while busy is ignored.
    start_frame(1'b0, 2, 0, 1, 8'h9C, 1'b1);
    chk("pin_c5_syms", 32'(exp_syms), 32'd2);
    @(posedge clk); #1;
    cfg_len = 8'd9;
    cfg_nsc = NSC_W'(7);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_frame("c5");

    // Starts with len=0 or nsc=0 are ignored; ofdm_cnt holds.
    cfg_nsc = NSC_W'(4);
    cfg_len = 8'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("len0_busy", 32'(busy), 32'd0);
      chk("len0_in_ready", 32'(in_ready), 32'd0);
      chk("len0_ofdm_cnt", 32'(ofdm_cnt), 32'd2);
    end
    @(posedge clk); #1;
    cfg_nsc = '0;
    cfg_len = 8'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("nsc0_busy", 32'(busy), 32'd0);
      chk("nsc0_map_valid", 32'(map_valid), 32'd0);
    end
    @(posedge clk); #1;

    // ofdm_cnt saturation: QPSK nsc=1, 70 bytes -> 280 symbols.
    start_frame(1'b0, 1, 0, 70, 8'h00, 1'b0);
    chk("pin_sat_syms", 32'(exp_syms), 32'd255);
    finish_frame("sat");

    // Randomized frames with source gaps and mapper backpressure.
    rand_ready = 1'b1;
    rand_gap   = 1'b1;
    for (int f = 0; f < 25; f++) begin
      logic q;
      int   nsc;
      int   p;
      int   len;
      q   = 1'($urandom_range(0, 1));
      nsc = $urandom_range(1, 20);
      p   = $urandom_range(0, 5);
      if (p == 1) p = 0;
      if (p != 0 && nsc < 2) nsc = 2;
      len = $urandom_range(1, 12);
      start_frame(q, nsc, p, len, 8'h00, 1'b0);
      finish_frame("rnd");
    end

    // Reset in the middle of a frame: outputs drop at once, no done.
    rand_ready = 1'b0;
    rand_gap   = 1'b0;
    start_frame(1'b0, 4, 2, 3, 8'h00, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_map_valid", 32'(map_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_ofdm_cnt", 32'(ofdm_cnt), 32'd0);
    exp_q.delete();
    byte_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
